// File: rtl/dafir_result_sink_pkg.sv
// Shared widths, defaults and the round/saturate conversion for the
// DA-FIR result sink.
package dafir_result_sink_pkg;

  localparam int RES_W     = 17;  // filter result width
  localparam int FRAC_DEF  = 7;   // default fractional bits in the result
  localparam int OUT_W_DEF = 8;   // default output sample width
  localparam int DROP_W    = 8;   // drop counter width

  // Rounded value (full 18-bit range, already clamped) plus clip indication.
  typedef struct packed {
    logic signed [RES_W:0] value;
    logic                  clipped;
  } conv_t;

  // Round half up to integer, then clamp to a signed out_w-bit range.
  function automatic conv_t round_sat(input logic signed [RES_W-1:0] res,
                                      input int frac,
                                      input int out_w);
    logic signed [RES_W:0] ext;
    logic signed [RES_W:0] rnd;
    logic signed [RES_W:0] shf;
    logic signed [RES_W:0] hi;
    logic signed [RES_W:0] lo;
    conv_t                 r;
    ext = {res[RES_W-1], res};
    rnd = ext + (18'sd1 <<< (frac - 1));
    shf = rnd >>> frac;
    hi  = (18'sd1 <<< (out_w - 1)) - 18'sd1;
    lo  = -(18'sd1 <<< (out_w - 1));
    if (shf > hi) begin
      r.value   = hi;
      r.clipped = 1'b1;
    end else if (shf < lo) begin
      r.value   = lo;
      r.clipped = 1'b1;
    end else begin
      r.value   = shf;
      r.clipped = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/dafir_result_sink_if.sv
// Result-in / sample-out bundle of the result sink. The sink is the slave,
// the filter core plus downstream consumer together act as master.
interface dafir_result_sink_if
  import dafir_result_sink_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF,
  parameter int DEPTH = 4
);

  logic signed [RES_W-1:0]       res_in;
  logic                          res_stb;
  logic signed [OUT_W-1:0]       out_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [$clog2(DEPTH):0]        fill;
  logic                          sat_flag;
  logic                          ovf_flag;
  logic [DROP_W-1:0]             drop_cnt;
  logic                          clr;

  modport master (
    output res_in, res_stb, out_ready, clr,
    input  out_data, out_valid, fill, sat_flag, ovf_flag, drop_cnt
  );

  modport slave (
    input  res_in, res_stb, out_ready, clr,
    output out_data, out_valid, fill, sat_flag, ovf_flag, drop_cnt
  );

endinterface

// File: rtl/dafir_sync_fifo.sv
// Single-clock FIFO with full/empty/count. A write while full is accepted
// only when a read happens in the same cycle; a read while empty is ignored.
module dafir_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_pop   = i_rd_en && !o_empty;
  assign w_push  = i_wr_en && (!o_full || w_pop);
  assign o_rd_data = r_mem[r_rd_ptr];

  // Storage write port.
  // NOTE: the array has no reset; emptiness comes from the count, so stale
  // contents are never visible and the RAM can map to plain storage.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers and count; pointers wrap naturally because DEPTH is a power of two.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/dafir_result_sink.sv
// Converts filter results to rounded, saturated samples, buffers them in a
// small FIFO towards a ready/valid consumer and keeps sticky status flags.
module dafir_result_sink
  import dafir_result_sink_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int FRAC  = FRAC_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic                clk_bit,
  input  logic                rst_n,
  dafir_result_sink_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  conv_t             w_conv;
  logic [OUT_W-1:0]  w_sample;
  logic [OUT_W-1:0]  w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_drop;
  logic [CNT_W-1:0]  w_count;
  logic              r_sat_flag;
  logic              r_ovf_flag;
  logic [DROP_W-1:0] r_drop_cnt;

  assign w_conv   = round_sat(bus.res_in, FRAC, OUT_W);
  // Value is already clamped to the OUT_W range, so the cast is lossless.
  assign w_sample = OUT_W'(w_conv.value);
  // Full FIFO only frees a slot when the head is popped in the same cycle.
  assign w_drop   = bus.res_stb && w_full && !bus.out_ready;

  dafir_sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk_bit),
    .rst_n     (rst_n),
    .i_wr_en   (bus.res_stb),
    .i_wr_data (w_sample),
    .i_rd_en   (bus.out_ready),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_empty ? '0 : w_head;
  assign bus.fill      = w_count;
  assign bus.sat_flag  = r_sat_flag;
  assign bus.ovf_flag  = r_ovf_flag;
  assign bus.drop_cnt  = r_drop_cnt;

  // Sticky status; a new event in the clear cycle takes priority over clr.
  always_ff @(posedge clk_bit or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_flag <= 1'b0;
      r_ovf_flag <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (bus.res_stb && w_conv.clipped) r_sat_flag <= 1'b1;
      else if (bus.clr)                  r_sat_flag <= 1'b0;

      if (w_drop)       r_ovf_flag <= 1'b1;
      else if (bus.clr) r_ovf_flag <= 1'b0;

      if (w_drop) begin
        if (bus.clr)                r_drop_cnt <= DROP_W'(1);
        else if (r_drop_cnt != '1)  r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      end else if (bus.clr) begin
        r_drop_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dafir_result_sink.sv
// Scoreboard bench for dafir_result_sink: accepted results are queued with
// their expected sample and compared when the consumer pops them.
module tb_dafir_result_sink;

  localparam int DEPTH = 4;

  logic clk_bit = 1'b0;
  logic rst_n   = 1'b0;

  dafir_result_sink_if #(.OUT_W(8), .DEPTH(DEPTH)) bus ();

  dafir_result_sink #(.DEPTH(DEPTH), .FRAC(7), .OUT_W(8)) dut (
    .clk_bit (clk_bit),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk_bit = ~clk_bit;

  int n_checks = 0;
  int n_errors = 0;
  int q[$];
  int m_fill = 0;
  int m_drop = 0;

  // Reference conversion: floor((v + 64) / 128), clamped to int8.
  function automatic int model_conv(input int v);
    int t;
    int r;
    t = v + 64;
    if (t >= 0) r = t / 128;
    else        r = -((-t + 127) / 128);
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  // One clock cycle of stimulus with scoreboard update and post-edge checks.
  task automatic cycle(input logic stb, input int val, input logic rdy, input logic c);
    bit pop;
    bit wr;
    bit drop;
    int exp_v;
    bus.res_stb   = stb;
    bus.res_in    = 17'(val);
    bus.out_ready = rdy;
    bus.clr       = c;
    pop  = rdy && (m_fill > 0);
    wr   = stb && ((m_fill < DEPTH) || pop);
    drop = stb && !wr;
    if (pop) begin
      exp_v = q.pop_front();
      n_checks++;
      if (bus.out_valid !== 1'b1 || int'(bus.out_data) !== exp_v) begin
        n_errors++;
        $display("FAIL pop_data: got valid=%b data=%0d expected valid=1 data=%0d",
                 bus.out_valid, int'(bus.out_data), exp_v);
      end
    end
    if (wr) q.push_back(model_conv(val));
    m_fill = m_fill + (wr ? 1 : 0) - (pop ? 1 : 0);
    if (c)                         m_drop = drop ? 1 : 0;
    else if (drop && m_drop < 255) m_drop++;
    @(posedge clk_bit);
    #1;
    bus.res_stb   = 1'b0;
    bus.out_ready = 1'b0;
    bus.clr       = 1'b0;
    n_checks++;
    if (int'(bus.fill) !== m_fill || int'(bus.drop_cnt) !== m_drop) begin
      n_errors++;
      $display("FAIL fill_drop: got fill=%0d drop=%0d expected fill=%0d drop=%0d",
               int'(bus.fill), int'(bus.drop_cnt), m_fill, m_drop);
    end
  endtask

  // Pop everything queued, then require an idle output.
  task automatic drain(input string name);
    for (int i = 0; i < 2 * DEPTH && m_fill > 0; i++) cycle(1'b0, 0, 1'b1, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'sd0) begin
      n_errors++;
      $display("FAIL %s_idle: got valid=%b data=%0d expected valid=0 data=0",
               name, bus.out_valid, int'(bus.out_data));
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'sd0 || bus.fill !== 3'd0 ||
        bus.sat_flag !== 1'b0 || bus.ovf_flag !== 1'b0 || bus.drop_cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_state: got valid=%b data=%0d fill=%0d sat=%b ovf=%b drop=%0d expected all 0",
               bus.out_valid, int'(bus.out_data), bus.fill, bus.sat_flag, bus.ovf_flag, bus.drop_cnt);
    end
    @(posedge clk_bit);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_convert();
    cycle(1'b1, 6400, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || int'(bus.out_data) !== 50 || bus.fill !== 3'd1) begin
      n_errors++;
      $display("FAIL conv_6400: got valid=%b data=%0d fill=%0d expected 1 50 1",
               bus.out_valid, int'(bus.out_data), bus.fill);
    end
    drain("conv_6400");
    cycle(1'b1, 64, 1'b0, 1'b0);
    n_checks++;
    if (int'(bus.out_data) !== 1) begin
      n_errors++;
      $display("FAIL conv_64: got %0d expected 1", int'(bus.out_data));
    end
    drain("conv_64");
    cycle(1'b1, -64, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || int'(bus.out_data) !== 0) begin
      n_errors++;
      $display("FAIL conv_m64: got valid=%b data=%0d expected 1 0", bus.out_valid, int'(bus.out_data));
    end
    drain("conv_m64");
    cycle(1'b1, -65, 1'b0, 1'b0);
    n_checks++;
    if (int'(bus.out_data) !== -1) begin
      n_errors++;
      $display("FAIL conv_m65: got %0d expected -1", int'(bus.out_data));
    end
    drain("conv_m65");
  endtask

  task automatic test_saturate();
    cycle(1'b1, 20000, 1'b0, 1'b0);
    n_checks++;
    if (int'(bus.out_data) !== 127 || bus.sat_flag !== 1'b1) begin
      n_errors++;
      $display("FAIL sat_pos: got data=%0d sat=%b expected 127 1", int'(bus.out_data), bus.sat_flag);
    end
    cycle(1'b1, -20000, 1'b0, 1'b0);
    drain("sat");
    cycle(1'b0, 0, 1'b0, 1'b1);
    n_checks++;
    if (bus.sat_flag !== 1'b0) begin
      n_errors++;
      $display("FAIL sat_clr: got %b expected 0", bus.sat_flag);
    end
    cycle(1'b1, -20000, 1'b0, 1'b1);
    n_checks++;
    if (bus.sat_flag !== 1'b1) begin
      n_errors++;
      $display("FAIL sat_wins_clr: got %b expected 1", bus.sat_flag);
    end
    drain("sat_wins");
    cycle(1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_full_drop();
    for (int i = 1; i <= 5; i++) cycle(1'b1, 128 * i, 1'b0, 1'b0);
    n_checks++;
    if (bus.fill !== 3'd4 || bus.ovf_flag !== 1'b1 || bus.drop_cnt !== 8'd1) begin
      n_errors++;
      $display("FAIL full_drop: got fill=%0d ovf=%b drop=%0d expected 4 1 1",
               bus.fill, bus.ovf_flag, bus.drop_cnt);
    end
    for (int i = 0; i < 260; i++) cycle(1'b1, 300, 1'b0, 1'b0);
    n_checks++;
    if (bus.drop_cnt !== 8'd255) begin
      n_errors++;
      $display("FAIL drop_sat: got %0d expected 255", bus.drop_cnt);
    end
    cycle(1'b1, 300, 1'b0, 1'b1);
    n_checks++;
    if (bus.drop_cnt !== 8'd1 || bus.ovf_flag !== 1'b1) begin
      n_errors++;
      $display("FAIL drop_wins_clr: got drop=%0d ovf=%b expected 1 1", bus.drop_cnt, bus.ovf_flag);
    end
    cycle(1'b0, 0, 1'b0, 1'b1);
    n_checks++;
    if (bus.drop_cnt !== 8'd0 || bus.ovf_flag !== 1'b0) begin
      n_errors++;
      $display("FAIL drop_clr: got drop=%0d ovf=%b expected 0 0", bus.drop_cnt, bus.ovf_flag);
    end
    drain("full_drop");
  endtask

  task automatic test_full_simul();
    for (int i = 1; i <= 4; i++) cycle(1'b1, 128 * i, 1'b0, 1'b0);
    cycle(1'b1, 640, 1'b1, 1'b0);
    n_checks++;
    if (bus.fill !== 3'd4 || bus.drop_cnt !== 8'd0 || bus.ovf_flag !== 1'b0) begin
      n_errors++;
      $display("FAIL full_simul: got fill=%0d drop=%0d ovf=%b expected 4 0 0",
               bus.fill, bus.drop_cnt, bus.ovf_flag);
    end
    drain("full_simul");
  endtask

  task automatic test_empty_simul();
    cycle(1'b1, 256, 1'b1, 1'b0);
    n_checks++;
    if (bus.fill !== 3'd1 || int'(bus.out_data) !== 2) begin
      n_errors++;
      $display("FAIL empty_simul: got fill=%0d data=%0d expected 1 2", bus.fill, int'(bus.out_data));
    end
    drain("empty_simul");
  endtask

  task automatic test_mid_reset();
    for (int i = 1; i <= 5; i++) cycle(1'b1, 128 * i, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'sd0 || bus.fill !== 3'd0 ||
        bus.ovf_flag !== 1'b0 || bus.sat_flag !== 1'b0 || bus.drop_cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL mid_reset: got valid=%b data=%0d fill=%0d ovf=%b sat=%b drop=%0d expected all 0",
               bus.out_valid, int'(bus.out_data), bus.fill, bus.ovf_flag, bus.sat_flag, bus.drop_cnt);
    end
    q.delete();
    m_fill = 0;
    m_drop = 0;
    @(posedge clk_bit);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 256, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || int'(bus.out_data) !== 2) begin
      n_errors++;
      $display("FAIL post_reset: got valid=%b data=%0d expected 1 2", bus.out_valid, int'(bus.out_data));
    end
    drain("post_reset");
  endtask

  initial begin
    bus.res_in    = '0;
    bus.res_stb   = 1'b0;
    bus.out_ready = 1'b0;
    bus.clr       = 1'b0;
    test_reset();
    test_convert();
    test_saturate();
    test_full_drop();
    test_full_simul();
    test_empty_simul();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
